// File: rtl/spi_target_pkg.sv
// Types and SPI mode constants shared by the SPI target and initiator.
// Mode 3: SCK idles high, data launched on falling edge, sampled on rising edge.
package spi_target_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic SPI_CPOL = 1'b1;
  localparam logic SPI_CPHA = 1'b1;
  localparam int   SPI_MODE = 3;

  // Reset values of the synchronizers match an idle, deselected bus.
  localparam logic SCK_IDLE = SPI_CPOL;
  localparam logic CS_IDLE  = 1'b1;
  localparam logic SDI_IDLE = 1'b0;

endpackage

// File: rtl/spi_target_sync_edge.sv
// N-stage synchronizer for one asynchronous input with rise/fall pulses on the
// synchronized value; pulses are combinational, one clk cycle wide.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;
  logic              q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      prev <= q;
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_target.sv
// SPI mode-3 target: oversampled SCK/CS/SDI, full-duplex shift of a SIZE-bit frame,
// with a loadable reply shadow and valid/error pulses when the frame closes.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int SIZE        = 40,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk_in,
  input  logic            reset_n_in,
  input  logic            clk_in_spi,
  input  logic            cs_in_n,
  input  logic            serial_in,
  output logic            serial_out,
  output logic            serial_oe_out,
  input  logic [SIZE-1:0] data_in,
  input  logic            load_in,
  output logic [SIZE-1:0] data_out,
  output logic            r_valid_out,
  output logic            r_error_out,
  output logic            r_busy_out
);

  localparam int            CW       = $clog2(SIZE + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(SIZE);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SIZE + 1);

  state_t                 state, state_nxt;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic                   sdi_s;
  logic [SIZE-1:0]        shadow, tx_shift, rx_shift;
  logic [CW-1:0]          bit_cnt;
  logic                   start, stop;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SCK_IDLE)) u_sck_sync (
    .clk   (clk_in),
    .rst_n (reset_n_in),
    .d     (clk_in_spi),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CS_IDLE)) u_cs_sync (
    .clk   (clk_in),
    .rst_n (reset_n_in),
    .d     (cs_in_n),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // SDI has the same depth as SCK so each sampled bit lines up with its edge.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      sdi_sync <= {SYNC_STAGES{SDI_IDLE}};
    end else begin
      sdi_sync[0] <= serial_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sdi_sync[i] <= sdi_sync[i-1];
      end
    end
  end
  assign sdi_s = sdi_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    stop      = 1'b0;
    if (state == IDLE && cs_fall) begin
      state_nxt = ACTIVE;
      start     = 1'b1;
    end else if (state == ACTIVE && cs_rise) begin
      state_nxt = IDLE;
      stop      = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      shadow      <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      data_out    <= '0;
      bit_cnt     <= '0;
      r_valid_out <= 1'b0;
      r_error_out <= 1'b0;
    end else begin
      r_valid_out <= 1'b0;
      r_error_out <= 1'b0;
      if (load_in) shadow <= data_in;
      if (start) begin
        // Reads the pre-load shadow, so a coincident load lands in the next frame.
        tx_shift <= shadow;
        rx_shift <= '0;
        bit_cnt  <= '0;
      end else if (stop) begin
        if (bit_cnt == CNT_FULL) begin
          data_out    <= rx_shift;
          r_valid_out <= 1'b1;
        end else begin
          r_error_out <= 1'b1;
        end
      end else if (state == ACTIVE) begin
        if (sck_rise) begin
          rx_shift <= {rx_shift[SIZE-2:0], sdi_s};
          if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + CW'(1);
        end
        // The leading falling edge of mode 3 precedes any sample and must not shift.
        if (sck_fall && bit_cnt != '0) begin
          tx_shift <= {tx_shift[SIZE-2:0], 1'b0};
        end
      end
    end
  end

  assign serial_oe_out = (state == ACTIVE);
  assign r_busy_out    = (state == ACTIVE);
  assign serial_out    = (state == ACTIVE) & tx_shift[SIZE-1];

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a behavioural mode-3 initiator drives frames while a
// scoreboard queue holds the expected valid/error pulse and data_out for each frame.
module tb_spi_target;

  localparam int SIZE = 40;

  logic            clk_in = 1'b0;
  logic            reset_n_in = 1'b0;
  logic            clk_in_spi = 1'b1;
  logic            cs_in_n = 1'b1;
  logic            serial_in = 1'b0;
  logic            serial_out;
  logic            serial_oe_out;
  logic [SIZE-1:0] data_in = '0;
  logic            load_in = 1'b0;
  logic [SIZE-1:0] data_out;
  logic            r_valid_out;
  logic            r_error_out;
  logic            r_busy_out;

  spi_target #(.SIZE(SIZE), .SYNC_STAGES(2)) dut (
    .clk_in        (clk_in),
    .reset_n_in    (reset_n_in),
    .clk_in_spi    (clk_in_spi),
    .cs_in_n       (cs_in_n),
    .serial_in     (serial_in),
    .serial_out    (serial_out),
    .serial_oe_out (serial_oe_out),
    .data_in       (data_in),
    .load_in       (load_in),
    .data_out      (data_out),
    .r_valid_out   (r_valid_out),
    .r_error_out   (r_error_out),
    .r_busy_out    (r_busy_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic            is_err;
    logic [SIZE-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   both_hi = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic is_err, input logic [SIZE-1:0] d);
    exp_t e;
    e.is_err = is_err;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  // Every pulse must be matched by a queued expectation of the same kind.
  always @(negedge clk_in) begin
    if (reset_n_in) begin
      if (r_valid_out && r_error_out) both_hi++;
      if (r_valid_out || r_error_out) begin
        chk("pulse_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pulse_kind_is_err", 64'(r_error_out), 64'(e.is_err));
          chk("data_out_at_pulse", 64'(data_out), 64'(e.data));
        end
      end
    end
  end

  task automatic do_load(input logic [SIZE-1:0] v);
    @(negedge clk_in);
    data_in = v;
    load_in = 1'b1;
    @(negedge clk_in);
    load_in = 1'b0;
  endtask

  // One mode-3 bit: drive SDI on SCK fall, sample SDO just before SCK rise.
  task automatic spi_bit(input logic b, output logic so);
    @(negedge clk_in);
    clk_in_spi = 1'b0;
    serial_in  = b;
    repeat (5) @(negedge clk_in);
    so = serial_out;
    clk_in_spi = 1'b1;
    repeat (5) @(negedge clk_in);
  endtask

  task automatic cs_low();
    @(negedge clk_in);
    cs_in_n = 1'b0;
    repeat (8) @(negedge clk_in);
  endtask

  task automatic cs_high();
    repeat (3) @(negedge clk_in);
    cs_in_n = 1'b1;
    repeat (10) @(negedge clk_in);
  endtask

  task automatic xfer(input logic [SIZE-1:0] mosi, input int n, input int load_at,
                      input logic [SIZE-1:0] load_val, output logic [SIZE:0] miso);
    logic b, so;
    miso = '0;
    for (int i = 0; i < n; i++) begin
      if (i == load_at) do_load(load_val);
      b = (i < SIZE) ? mosi[SIZE-1-i] : 1'b0;
      spi_bit(b, so);
      miso = {miso[SIZE-1:0], so};
    end
  endtask

  task automatic frame(input logic [SIZE-1:0] mosi, input int n, input int load_at,
                       input logic [SIZE-1:0] load_val, output logic [SIZE:0] miso);
    cs_low();
    xfer(mosi, n, load_at, load_val, miso);
    cs_high();
  endtask

  initial begin
    logic [SIZE:0]   miso;
    logic [SIZE-1:0] last_data;
    last_data = '0;

    // Reset state
    repeat (3) @(negedge clk_in);
    chk("rst_data_out", 64'(data_out), 64'(0));
    chk("rst_serial_oe", 64'(serial_oe_out), 64'(0));
    chk("rst_serial_out", 64'(serial_out), 64'(0));
    chk("rst_busy", 64'(r_busy_out), 64'(0));
    reset_n_in = 1'b1;
    repeat (5) @(negedge clk_in);

    // Full 40-bit exchange
    do_load(40'hA5_1234_5678);
    push_exp(1'b0, 40'h12_3456_789A);
    cs_low();
    chk("active_oe", 64'(serial_oe_out), 64'(1));
    chk("active_busy", 64'(r_busy_out), 64'(1));
    xfer(40'h12_3456_789A, 40, -1, '0, miso);
    cs_high();
    chk("full_miso", 64'(miso[SIZE-1:0]), 64'h00A5_1234_5678);
    chk("idle_oe", 64'(serial_oe_out), 64'(0));
    last_data = 40'h12_3456_789A;

    // Short frame of 20 bits
    push_exp(1'b1, last_data);
    frame(40'hFF_FF0F_0000, 20, -1, '0, miso);
    chk("short_miso_top20", 64'(miso[19:0]), 64'h0_0000_000A_5123);
    chk("short_data_kept", 64'(data_out), 64'(last_data));

    // Over-length frame of 41 bits
    push_exp(1'b1, last_data);
    frame(40'h55_5555_5555, 41, -1, '0, miso);
    chk("long_miso_40", 64'(miso[SIZE:1]), 64'h00A5_1234_5678);
    chk("long_bit41_zero", 64'(miso[0]), 64'(0));
    chk("long_data_kept", 64'(data_out), 64'(last_data));

    // Reload during a frame only affects the following frame
    do_load(40'hFF_FFFF_FFFF);
    push_exp(1'b0, 40'h0F_0F0F_0F0F);
    frame(40'h0F_0F0F_0F0F, 40, 20, 40'h1, miso);
    chk("midload_cur_ones", 64'(miso[SIZE-1:0]), 64'h00FF_FFFF_FFFF);
    push_exp(1'b0, 40'h01_2345_6789);
    frame(40'h01_2345_6789, 40, -1, '0, miso);
    chk("midload_next_one", 64'(miso[SIZE-1:0]), 64'h1);
    last_data = 40'h01_2345_6789;

    // Reset in the middle of a frame
    cs_low();
    xfer(40'hCC_CCCC_CCCC, 10, -1, '0, miso);
    @(negedge clk_in);
    reset_n_in = 1'b0;
    #1;
    chk("midrst_data_out", 64'(data_out), 64'(0));
    chk("midrst_oe", 64'(serial_oe_out), 64'(0));
    chk("midrst_busy", 64'(r_busy_out), 64'(0));
    chk("midrst_serial_out", 64'(serial_out), 64'(0));
    chk("midrst_pulses", 64'({r_valid_out, r_error_out}), 64'(0));
    cs_in_n    = 1'b1;
    clk_in_spi = 1'b1;
    repeat (4) @(negedge clk_in);
    reset_n_in = 1'b1;
    repeat (5) @(negedge clk_in);
    push_exp(1'b0, 40'hDE_ADBE_EF00);
    frame(40'hDE_ADBE_EF00, 40, -1, '0, miso);
    chk("postrst_miso_zero", 64'(miso[SIZE-1:0]), 64'(0));
    chk("postrst_data_out", 64'(data_out), 64'h00DE_ADBE_EF00);
    last_data = 40'hDE_ADBE_EF00;

    // Chip select toggled with no SCK
    push_exp(1'b1, last_data);
    chk("nosck_oe_before", 64'(serial_oe_out), 64'(0));
    cs_low();
    chk("nosck_oe_low", 64'(serial_oe_out), 64'(1));
    cs_high();
    chk("nosck_oe_after", 64'(serial_oe_out), 64'(0));
    chk("nosck_data_kept", 64'(data_out), 64'(last_data));

    repeat (10) @(negedge clk_in);
    chk("all_pulses_seen", 64'(exp_q.size()), 64'(0));
    chk("valid_error_exclusive", 64'(both_hi), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
